stream_checker: RTL and testbench
=================================

// Module: stream_checker
// PURPOSE
//  Parametrised multi-channel output sink for core-complex benches: successor to the fixed 4-lane outrow.
//  Accepts CH output streams over the write/read handshake and compares each value against expected data.
//  Keeps pass/total/error counters, captures the first mismatch, flags over-long streams,
//  and can inject pseudo-random back-pressure.
// PARAMETERS
//  CH      4   number of channels
//  WIDTH   11  data width, signed two's complement
//  MAXLEN  39  max expected values per channel; data array depth is CH*MAXLEN
//  LW      6   width of length entries
//  CW      8   width of correct/count/errors counters
//  SEED    16'hACE1  reset value of the 16-bit stall LFSR; must be non-zero
// PORTS
//  clk       in   1            clock
//  rst       in   1            synchronous active-high reset
//  length    in   [LW]x CH     expected stream length per channel; unpacked array [0:CH-1]
//  data      in   [WIDTH]x CH*MAXLEN  expected values; channel i at [i*MAXLEN +: MAXLEN]
//  write     in   CH           producer holds in[i] valid while write[i]=1
//  in        in   [WIDTH]x CH  stream values; unpacked array [0:CH-1]
//  stall_en  in   1            enable random back-pressure
//  read      out  CH           one-cycle accept pulse per channel
//  count     out  CW           total values accepted; saturating
//  correct   out  CW           accepted values equal to expected; saturating
//  errors    out  CW           mismatches + overflow events; saturating
//  done      out  CH           channel received `length` values
//  all_done  out  1            &done
//  overflow  out  CH           sticky: write seen on a channel already in DONE
//  err_valid out  1            first mismatch captured
//  err_chan  out  $clog2(CH)   channel of first mismatch
//  err_idx   out  LW           stream index of first mismatch
//  err_value out  WIDTH        received value at first mismatch
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - All outputs 0; per-channel idx=0; LFSR=SEED.
//  - length sampled every reset cycle into len_q; len_q clamped to MAXLEN.
//  - Channel state <= DONE (done=1) if clamped length==0, else RUN.
//  Per-channel FSM {RUN, ACK, DONE}:
//  - RUN: if write[i] && !stall[i]:
//    - compare in[i] with data[i*MAXLEN+idx];
//    - read[i]<=1; idx<=idx+1; -> ACK.
//  - ACK: read[i]<=0; -> DONE if idx==len_q, else RUN. The write sample during ACK is ignored.
//  - DONE: done[i]=1; read stays 0.
//    - write[i]=1 while in DONE and overflow[i]==0: set overflow[i], errors+1 (once per channel).
//  - Throughput: max 1 value per 2 cycles per channel. read rises the cycle after write is seen.
//  Stall:
//  - stall[i] = stall_en & lfsr[i%16].
//  - LFSR is Fibonacci x^16+x^14+x^13+x^11+1, advancing every non-reset cycle.
//  Counters:
//  - count += popcount of channels leaving RUN this cycle.
//  - correct += matches among those; errors += mismatches + new overflows.
//  - All counters saturate at 2^CW-1, never wrap.
//  First-error capture:
//  - Latched on the first cycle with any mismatch; lowest channel index wins ties.
//  - Frozen until reset.
//  - err_idx = stream index before increment.
//  Compare rule: full-width equality; -1 (11'h7FF) != 1023.
//  Reset mid-operation: read drops the next cycle. In-flight captures are discarded, not counted.
// TESTING
//  1 CH=4, lengths {3,3,3,3}, producer sends exact data, stall_en=0
//    -> each read pulses 3x, 2 cycles apart; count=12, correct=12, errors=0, all_done=1 by cycle 7 after first write.
//  2 ch1 value index 2 sent as -5, expected 7
//    -> errors=1, correct=11, err_valid=1, err_chan=1, err_idx=2, err_value=11'h7FB.
//  3 ch0 and ch2 mismatch in the same cycle
//    -> errors+=2, err_chan=0.
//  4 ch3 length=2, producer keeps write high after 2nd accept
//    -> overflow[3]=1, errors=1, no 3rd read pulse.
//  5 stall_en=1, lengths {20,20,20,20}
//    -> identical final counters to the stall_en=0 run; at least one read gap >2 cycles.
//    Also: length=0 channel done=1 right after reset; length=63 clamps to 39.
//  6 CW=4, 20 accepted values -> count sticks at 15.
//    Assert rst during a stream -> read=0 and counters=0 next cycle; restart passes.

Source files
------------

// File: rtl/stream_checker.sv
// stream_checker
//   Multi-channel output sink. Each of CH channels accepts a stream of signed
//   values over a write/read handshake and compares every accepted value with
//   the expected value held in the flat `data` array. Tracks saturating
//   totals (count/correct/errors), captures the first mismatch, flags writes
//   that arrive after a channel has completed, and can inject pseudo-random
//   back-pressure from a 16-bit Fibonacci LFSR.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   length      expected stream length per channel (clamped to MAXLEN)
//   data        expected values; channel i occupies [i*MAXLEN +: MAXLEN]
//   write, in   producer valid and value per channel
//   stall_en    enable random back-pressure
//   read        one-cycle accept pulse per channel
//   count       accepted values (saturating)
//   correct     accepted values equal to expected (saturating)
//   errors      mismatches plus overflow events (saturating)
//   done        channel has received its full stream
//   all_done    every channel done
//   overflow    sticky: write seen on a completed channel
//   err_valid, err_chan, err_idx, err_value   first-mismatch capture
module stream_checker #(
  parameter int          CH     = 4,
  parameter int          WIDTH  = 11,
  parameter int          MAXLEN = 39,
  parameter int          LW     = 6,
  parameter int          CW     = 8,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int         CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LW-1:0]           length    [0:CH-1],
  input  logic signed [WIDTH-1:0] data      [0:CH*MAXLEN-1],
  input  logic [CH-1:0]           write,
  input  logic signed [WIDTH-1:0] in        [0:CH-1],
  input  logic                    stall_en,
  output logic [CH-1:0]           read,
  output logic [CW-1:0]           count,
  output logic [CW-1:0]           correct,
  output logic [CW-1:0]           errors,
  output logic [CH-1:0]           done,
  output logic                    all_done,
  output logic [CH-1:0]           overflow,
  output logic                    err_valid,
  output logic [CHW-1:0]          err_chan,
  output logic [LW-1:0]           err_idx,
  output logic signed [WIDTH-1:0] err_value
);

  localparam int AW = $clog2(CH*MAXLEN);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state [CH];
  logic [LW-1:0] idx   [CH];
  logic [LW-1:0] len_q [CH];
  logic [15:0]   lfsr;

  logic [CH-1:0] stall_p0;
  logic [CH-1:0] accept_p0;
  logic [CH-1:0] match_p0;
  logic [CH-1:0] ovf_new_p0;
  logic [AW-1:0] addr_p0 [CH];
  logic [7:0]    n_acc_p0;
  logic [7:0]    n_match_p0;
  logic [7:0]    n_err_p0;
  logic                    fe_hit_p0;
  logic [CHW-1:0]          fe_chan_p0;
  logic [LW-1:0]           fe_idx_p0;
  logic signed [WIDTH-1:0] fe_val_p0;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (int'(l) > MAXLEN) return LW'(MAXLEN);
    return l;
  endfunction

  // Add a small increment, pinning at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [7:0]    inc);
    logic [CW+8:0] s;
    s = {9'd0, a} + {{(CW+1){1'b0}}, inc};
    if (s > {9'd0, {CW{1'b1}}}) return {CW{1'b1}};
    return s[CW-1:0];
  endfunction

  // ---- Stage p0: per-channel decode of this cycle's handshake ----
  // Channels are scanned from the highest index down so that the lowest
  // mismatching channel is the last writer of the first-error candidate.
  always_comb begin
    stall_p0   = '0;
    accept_p0  = '0;
    match_p0   = '0;
    ovf_new_p0 = '0;
    n_acc_p0   = '0;
    n_match_p0 = '0;
    n_err_p0   = '0;
    fe_hit_p0  = 1'b0;
    fe_chan_p0 = '0;
    fe_idx_p0  = '0;
    fe_val_p0  = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      addr_p0[i]    = AW'(i * MAXLEN) + AW'(idx[i]);
      stall_p0[i]   = stall_en & lfsr[4'(i % 16)];
      accept_p0[i]  = (state[i] == S_RUN) && write[i] && !stall_p0[i];
      match_p0[i]   = (in[i] == data[addr_p0[i]]);
      ovf_new_p0[i] = (state[i] == S_DONE) && write[i] && !overflow[i];
      if (accept_p0[i]) begin
        n_acc_p0 = n_acc_p0 + 8'd1;
        if (match_p0[i]) begin
          n_match_p0 = n_match_p0 + 8'd1;
        end else begin
          n_err_p0   = n_err_p0 + 8'd1;
          fe_hit_p0  = 1'b1;
          fe_chan_p0 = CHW'(i);
          fe_idx_p0  = idx[i];
          fe_val_p0  = in[i];
        end
      end
      if (ovf_new_p0[i]) n_err_p0 = n_err_p0 + 8'd1;
    end
  end

  // ---- Stage p1: registered channel state, counters and capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      read      <= '0;
      count     <= '0;
      correct   <= '0;
      errors    <= '0;
      overflow  <= '0;
      err_valid <= 1'b0;
      err_chan  <= '0;
      err_idx   <= '0;
      err_value <= '0;
      for (int i = 0; i < CH; i++) begin
        len_q[i] <= clamp_len(length[i]);
        idx[i]   <= '0;
        state[i] <= (clamp_len(length[i]) == '0) ? S_DONE : S_RUN;
      end
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      count    <= sat_add(count, n_acc_p0);
      correct  <= sat_add(correct, n_match_p0);
      errors   <= sat_add(errors, n_err_p0);
      overflow <= overflow | ovf_new_p0;
      if (!err_valid && fe_hit_p0) begin
        err_valid <= 1'b1;
        err_chan  <= fe_chan_p0;
        err_idx   <= fe_idx_p0;
        err_value <= fe_val_p0;
      end
      for (int i = 0; i < CH; i++) begin
        read[i] <= 1'b0;
        case (state[i])
          S_RUN: begin
            if (accept_p0[i]) begin
              read[i]  <= 1'b1;
              idx[i]   <= idx[i] + LW'(1);
              state[i] <= S_ACK;
            end
          end
          // The write sample during ACK is deliberately ignored, giving the
          // producer one cycle to present its next value.
          S_ACK:   state[i] <= (idx[i] == len_q[i]) ? S_DONE : S_RUN;
          S_DONE:  state[i] <= S_DONE;
          default: state[i] <= S_DONE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) done[i] = (state[i] == S_DONE);
    all_done = &done;
  end

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: directed scenarios plus randomized streams,
// checked every cycle against a transaction-level model of the checker.
module tb_stream_checker;

  localparam int CH = 4, WIDTH = 11, MAXLEN = 39, LW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [LW-1:0]           length [0:CH-1];
  logic signed [WIDTH-1:0] data   [0:CH*MAXLEN-1];
  logic [CH-1:0]           write;
  logic signed [WIDTH-1:0] in_v   [0:CH-1];
  logic                    stall_en;

  logic [CH-1:0] read_a, done_a, ovf_a, read_b, done_b, ovf_b;
  logic [7:0] count_a, correct_a, errors_a;
  logic [3:0] count_b, correct_b, errors_b;
  logic all_done_a, all_done_b, ev_a, ev_b;
  logic [1:0] ech_a, ech_b;
  logic [LW-1:0] eidx_a, eidx_b;
  logic signed [WIDTH-1:0] eval_a, eval_b;

  stream_checker #(.CH(CH), .WIDTH(WIDTH), .MAXLEN(MAXLEN), .LW(LW), .CW(8)) dut (
    .clk(clk), .rst(rst), .length(length), .data(data), .write(write), .in(in_v),
    .stall_en(stall_en), .read(read_a), .count(count_a), .correct(correct_a),
    .errors(errors_a), .done(done_a), .all_done(all_done_a), .overflow(ovf_a),
    .err_valid(ev_a), .err_chan(ech_a), .err_idx(eidx_a), .err_value(eval_a));

  stream_checker #(.CH(CH), .WIDTH(WIDTH), .MAXLEN(MAXLEN), .LW(LW), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .length(length), .data(data), .write(write), .in(in_v),
    .stall_en(stall_en), .read(read_b), .count(count_b), .correct(correct_b),
    .errors(errors_b), .done(done_b), .all_done(all_done_b), .overflow(ovf_b),
    .err_valid(ev_b), .err_chan(ech_b), .err_idx(eidx_b), .err_value(eval_b));

  int n_chk = 0, n_fail = 0, cyc = 0;

  // ---------------- behavioural model ----------------
  int m_len [CH];
  int m_n   [CH];   // values accepted so far
  bit m_gap [CH];   // accepted last cycle: this cycle's write is ignored
  bit m_ovf [CH];
  bit [CH-1:0] m_read;
  int m_cnt, m_cor, m_err, m_cnt4, m_cor4, m_err4;
  bit m_ev;
  int m_ech, m_eidx;
  logic signed [WIDTH-1:0] m_eval;
  logic [15:0] m_lfsr;

  function automatic bit m_done(int i);
    return (m_n[i] == m_len[i]) && !m_gap[i];
  endfunction

  function automatic int satv(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update();
    int acc, mat, bad;
    bit hit, st;
    bit [CH-1:0] rd;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_len[i] = (int'(length[i]) > MAXLEN) ? MAXLEN : int'(length[i]);
        m_n[i] = 0; m_gap[i] = 0; m_ovf[i] = 0;
      end
      m_read = '0;
      m_cnt = 0; m_cor = 0; m_err = 0; m_cnt4 = 0; m_cor4 = 0; m_err4 = 0;
      m_ev = 0; m_ech = 0; m_eidx = 0; m_eval = '0;
      m_lfsr = 16'hACE1;
    end else begin
      acc = 0; mat = 0; bad = 0; hit = 0; rd = '0;
      for (int i = 0; i < CH; i++) begin
        st = stall_en && m_lfsr[i % 16];
        if (m_gap[i]) begin
          m_gap[i] = 0;
        end else if (m_n[i] == m_len[i]) begin
          if (write[i] && !m_ovf[i]) begin m_ovf[i] = 1; bad++; end
        end else if (write[i] && !st) begin
          acc++;
          if (in_v[i] == data[i*MAXLEN + m_n[i]]) mat++;
          else begin
            bad++;
            if (!m_ev && !hit) begin
              hit = 1; m_ech = i; m_eidx = m_n[i]; m_eval = in_v[i];
            end
          end
          m_n[i]++; m_gap[i] = 1; rd[i] = 1;
        end
      end
      m_read = rd;
      if (hit) m_ev = 1;
      m_cnt  = satv(m_cnt + acc, 255); m_cor  = satv(m_cor + mat, 255); m_err  = satv(m_err + bad, 255);
      m_cnt4 = satv(m_cnt4 + acc, 15); m_cor4 = satv(m_cor4 + mat, 15); m_err4 = satv(m_err4 + bad, 15);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare();
    bit [CH-1:0] ed, eo;
    for (int i = 0; i < CH; i++) begin ed[i] = m_done(i); eo[i] = m_ovf[i]; end
    chk("read", {28'd0, read_a}, {28'd0, m_read});
    chk("count", {24'd0, count_a}, m_cnt);
    chk("correct", {24'd0, correct_a}, m_cor);
    chk("errors", {24'd0, errors_a}, m_err);
    chk("done", {28'd0, done_a}, {28'd0, ed});
    chk("all_done", {31'd0, all_done_a}, {31'd0, &ed});
    chk("overflow", {28'd0, ovf_a}, {28'd0, eo});
    chk("err_valid", {31'd0, ev_a}, {31'd0, m_ev});
    chk("err_chan", {30'd0, ech_a}, m_ech);
    chk("err_idx", {26'd0, eidx_a}, m_eidx);
    chk("err_value", {21'd0, eval_a}, {21'd0, m_eval});
    chk("read_cw4", {28'd0, read_b}, {28'd0, m_read});
    chk("count_cw4", {28'd0, count_b}, m_cnt4);
    chk("correct_cw4", {28'd0, correct_b}, m_cor4);
    chk("errors_cw4", {28'd0, errors_b}, m_err4);
  endtask

  // ---------------- producer ----------------
  int p [CH];
  int plen [CH];
  bit keep [CH];
  bit idle_en;
  logic signed [WIDTH-1:0] sv [CH][MAXLEN];
  int rcount [CH];
  int last_rd [CH];
  int maxgap;

  task automatic drive();
    for (int i = 0; i < CH; i++) begin
      if (p[i] < plen[i]) begin
        write[i] = idle_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_v[i]  = sv[i][p[i]];
      end else begin
        write[i] = keep[i];
        in_v[i]  = WIDTH'($urandom);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare();
    cyc++;
    for (int i = 0; i < CH; i++) begin
      if (read_a[i]) begin
        rcount[i]++;
        if (last_rd[i] >= 0 && cyc - last_rd[i] > maxgap) maxgap = cyc - last_rd[i];
        last_rd[i] = cyc;
      end
      if (rst) p[i] = 0;
      else if (m_read[i]) p[i]++;
    end
    drive();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < CH; i++) begin rcount[i] = 0; last_rd[i] = -1; end
    maxgap = 0;
  endtask

  // New random expected data; producer sends it unchanged.
  task automatic fill_data();
    for (int j = 0; j < CH*MAXLEN; j++) data[j] = WIDTH'($urandom);
    for (int i = 0; i < CH; i++)
      for (int k = 0; k < MAXLEN; k++) sv[i][k] = data[i*MAXLEN + k];
  endtask

  task automatic do_reset(input int l0, input int l1, input int l2, input int l3);
    int ls [CH];
    ls = '{l0, l1, l2, l3};
    rst = 1'b1;
    for (int i = 0; i < CH; i++) begin
      length[i] = LW'(ls[i]);
      plen[i] = (ls[i] > MAXLEN) ? MAXLEN : ls[i];
      p[i] = 0;
    end
    cycle();
    cycle();
    rst = 1'b0;
    clear_stats();
  endtask

  function automatic bit model_all_done();
    for (int i = 0; i < CH; i++) if (!m_done(i)) return 0;
    return 1;
  endfunction

  task automatic run_to_done(input int budget);
    int k = 0;
    while (!model_all_done() && k < budget) begin cycle(); k++; end
    if (k >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL run_timeout: got %0d cycles required <%0d", k, budget);
    end
    cycle(); cycle();
  endtask

  int sv_cnt, sv_cor, sv_err;

  initial begin
    rst = 1'b1; stall_en = 1'b0; idle_en = 1'b0; write = '0;
    for (int i = 0; i < CH; i++) begin keep[i] = 0; in_v[i] = '0; end
    fill_data();

    // 1: exact data, lengths 3, no stall
    do_reset(3, 3, 3, 3);
    chk("reset_count", {24'd0, count_a}, 0);
    chk("reset_read", {28'd0, read_a}, 0);
    repeat (6) cycle();
    chk("t1_all_done", {31'd0, all_done_a}, 1);
    chk("t1_count", {24'd0, count_a}, 12);
    chk("t1_correct", {24'd0, correct_a}, 12);
    chk("t1_errors", {24'd0, errors_a}, 0);
    chk("t1_reads_ch0", rcount[0], 3);
    chk("t1_gap", maxgap, 2);

    // 2: ch1 index 2 expected 7, sent -5
    fill_data();
    data[1*MAXLEN + 2] = 11'sd7;
    sv[1][2] = -11'sd5;
    do_reset(3, 3, 3, 3);
    repeat (8) cycle();
    chk("t2_errors", {24'd0, errors_a}, 1);
    chk("t2_correct", {24'd0, correct_a}, 11);
    chk("t2_err_valid", {31'd0, ev_a}, 1);
    chk("t2_err_chan", {30'd0, ech_a}, 1);
    chk("t2_err_idx", {26'd0, eidx_a}, 2);
    chk("t2_err_value", {21'd0, eval_a}, 32'h7FB);

    // 3: ch0 and ch2 mismatch in the same cycle
    fill_data();
    sv[0][0] = data[0] ^ 11'sd1;
    sv[2][0] = data[2*MAXLEN] ^ 11'sd2;
    do_reset(3, 3, 3, 3);
    repeat (8) cycle();
    chk("t3_errors", {24'd0, errors_a}, 2);
    chk("t3_err_chan", {30'd0, ech_a}, 0);
    chk("t3_err_idx", {26'd0, eidx_a}, 0);

    // 4: ch3 length 2, producer keeps writing afterwards
    fill_data();
    keep[3] = 1;
    do_reset(3, 3, 3, 2);
    repeat (12) cycle();
    chk("t4_overflow", {28'd0, ovf_a}, 32'h8);
    chk("t4_errors", {24'd0, errors_a}, 1);
    chk("t4_reads_ch3", rcount[3], 2);
    keep[3] = 0;

    // 5: lengths 20, without then with stall; CW=4 count sticks at 15
    fill_data();
    do_reset(20, 20, 20, 20);
    run_to_done(200);
    chk("t5_count", {24'd0, count_a}, 80);
    chk("t5_count_cw4", {28'd0, count_b}, 15);
    sv_cnt = count_a; sv_cor = correct_a; sv_err = errors_a;
    stall_en = 1'b1;
    do_reset(20, 20, 20, 20);
    run_to_done(2000);
    chk("t5_stall_count", {24'd0, count_a}, sv_cnt);
    chk("t5_stall_correct", {24'd0, correct_a}, sv_cor);
    chk("t5_stall_errors", {24'd0, errors_a}, sv_err);
    chk("t5_stall_gap", {31'd0, maxgap > 2}, 1);
    stall_en = 1'b0;

    // length 0 done at once; length 63 clamps to 39
    do_reset(0, 63, 1, 1);
    chk("t5_len0_done", {31'd0, done_a[0]}, 1);
    run_to_done(200);
    chk("t5_clamp_count", {24'd0, count_a}, 41);
    chk("t5_clamp_reads", rcount[1], 39);

    // 6: reset in the middle of a stream, then a clean restart
    do_reset(20, 20, 20, 20);
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    chk("t6_read_after_rst", {28'd0, read_a}, 0);
    chk("t6_count_after_rst", {24'd0, count_a}, 0);
    rst = 1'b0;
    run_to_done(200);
    chk("t6_restart_count", {24'd0, count_a}, 80);
    chk("t6_restart_correct", {24'd0, correct_a}, 80);

    // randomized streams
    for (int it = 0; it < 30; it++) begin
      int l [CH];
      fill_data();
      for (int i = 0; i < CH; i++) begin
        l[i] = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 63);
        keep[i] = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < MAXLEN; k++)
          if ($urandom_range(0, 7) == 0) sv[i][k] = data[i*MAXLEN + k] ^ WIDTH'($urandom_range(1, 2047));
      end
      stall_en = 1'($urandom_range(0, 1));
      idle_en  = 1'($urandom_range(0, 1));
      do_reset(l[0], l[1], l[2], l[3]);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      run_to_done(1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
